// File: rtl/seg_scan_driver_pkg.sv
// Shared seven-segment constants and bus-width helpers for the display stages.
// Codes are active-low cathodes ordered {g,f,e,d,c,b,a}.
package seg_scan_driver_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Width of a packed bus carrying n 4-bit digits.
  function automatic int dig_bus_w(input int n);
    return DIGIT_W * n;
  endfunction

endpackage

// File: rtl/seg_scan_driver_decode.sv
// Combinational hex-to-seven-segment decoder with a blank override.
// Output is active-low; blank forces all segments off.
module seg7_decode
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] i_val,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_val)
        4'h0: o_seg = SEG_0;
        4'h1: o_seg = SEG_1;
        4'h2: o_seg = SEG_2;
        4'h3: o_seg = SEG_3;
        4'h4: o_seg = SEG_4;
        4'h5: o_seg = SEG_5;
        4'h6: o_seg = SEG_6;
        4'h7: o_seg = SEG_7;
        4'h8: o_seg = SEG_8;
        4'h9: o_seg = SEG_9;
        4'hA: o_seg = SEG_A;
        4'hB: o_seg = SEG_B;
        4'hC: o_seg = SEG_C;
        4'hD: o_seg = SEG_D;
        4'hE: o_seg = SEG_E;
        default: o_seg = SEG_F;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scanner: per-frame input snapshot, leading-zero
// blanking, per-digit decimal points and 16-level PWM brightness.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_LOG2 = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               en,
  input  logic                               blank_lz,
  input  logic [dig_bus_w(NUM_DIGITS)-1:0]   dig_in,
  input  logic [NUM_DIGITS-1:0]              dp_in,
  input  logic [3:0]                         bright,
  output logic [NUM_DIGITS-1:0]              an,
  output logic [6:0]                         seg,
  output logic                               dp,
  output logic                               frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0]        IDX_ONE   = IDX_W'(1);
  localparam logic [REFRESH_LOG2-1:0] PRESC_MAX = '1;
  localparam logic [REFRESH_LOG2-1:0] PRESC_ONE = REFRESH_LOG2'(1);

  logic [REFRESH_LOG2-1:0]            r_presc;
  logic [IDX_W-1:0]                   r_idx;
  logic [dig_bus_w(NUM_DIGITS)-1:0]   r_shadow_dig;
  logic [NUM_DIGITS-1:0]              r_shadow_dp;
  logic [NUM_DIGITS-1:0]              r_an;
  logic [6:0]                         r_seg;
  logic                               r_dp;
  logic                               r_frame_tick;

  logic                               w_slot_end;
  logic                               w_frame_start;
  logic [3:0]                         w_cur_val;
  logic [NUM_DIGITS-1:0]              w_lz_mask;
  logic                               w_cur_blank;
  logic                               w_cur_dp;
  logic [3:0]                         w_pwm_top;
  logic                               w_on;
  logic [6:0]                         w_dec_seg;
  logic [NUM_DIGITS-1:0]              w_an_next;

  assign w_slot_end    = en && (r_presc == PRESC_MAX);
  assign w_frame_start = w_slot_end && (r_idx == LAST_IDX);

  assign w_cur_val   = r_shadow_dig[r_idx*DIGIT_W +: DIGIT_W];
  assign w_cur_blank = w_lz_mask[r_idx];
  assign w_cur_dp    = r_shadow_dp[r_idx];

  // Digit k is a leading zero when it and every higher digit are zero.
  always_comb begin
    logic v_zero_tail;
    w_lz_mask   = '0;
    v_zero_tail = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      v_zero_tail  = v_zero_tail && (r_shadow_dig[k*DIGIT_W +: DIGIT_W] == 4'd0);
      w_lz_mask[k] = blank_lz && v_zero_tail;
    end
  end

  // Prescaler 0 is the anti-ghosting dead cycle. The prescaler==1 term keeps
  // bright=0 at one lit cycle even when the slot is exactly 16 cycles long.
  assign w_pwm_top = r_presc[REFRESH_LOG2-1 -: 4];
  assign w_on      = en && (r_presc != '0) &&
                     ((w_pwm_top <= bright) || (r_presc == PRESC_ONE));

  seg7_decode u_decode (
    .i_val   (w_cur_val),
    .i_blank (w_cur_blank),
    .o_seg   (w_dec_seg)
  );

  always_comb begin
    w_an_next = '1;
    if (w_on) w_an_next[r_idx] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_shadow_dig <= '0;
      r_shadow_dp  <= '0;
      r_an         <= '1;
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      if (en) begin
        r_presc <= r_presc + PRESC_ONE;
        if (w_slot_end) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_ONE;
      end
      if (w_frame_start) begin
        r_shadow_dig <= dig_in;
        r_shadow_dp  <= dp_in;
      end
      r_frame_tick <= w_frame_start;
      r_an         <= w_an_next;
      r_seg        <= w_on ? w_dec_seg : SEG_BLANK;
      r_dp         <= ~(w_on && w_cur_dp);
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with 4 digits and 16-cycle slots.
// Each frame is captured over 64 samples and compared with hand-derived codes.
module tb_seg_scan_driver;

  logic        clk;
  logic        reset;
  logic        en;
  logic        blank_lz;
  logic [15:0] dig_in;
  logic [3:0]  dp_in;
  logic [3:0]  bright;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;
  int multi_low = 0;

  int         low_cnt[4];
  logic [6:0] seg_seen[4];
  logic       dp_seen[4];
  int         first_pos[4];
  int         tick_pos;

  seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_LOG2(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .blank_lz   (blank_lz),
    .dig_in     (dig_in),
    .dp_in      (dp_in),
    .bright     (bright),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if ($countones(~an) > 1) multi_low++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Samples one 64-cycle frame; optionally replaces dig_in at sample change_at.
  task automatic capture_frame(input int change_at, input logic [15:0] new_dig);
    for (int d = 0; d < 4; d++) begin
      low_cnt[d]   = 0;
      seg_seen[d]  = 7'h00;
      dp_seen[d]   = 1'b1;
      first_pos[d] = 99;
    end
    tick_pos = 0;
    for (int s = 1; s <= 64; s++) begin
      @(negedge clk);
      if (s == change_at) dig_in = new_dig;
      if (frame_tick && tick_pos == 0) tick_pos = s;
      for (int d = 0; d < 4; d++) begin
        if (!an[d]) begin
          low_cnt[d]++;
          seg_seen[d] = seg;
          dp_seen[d]  = dp;
          if (first_pos[d] == 99) first_pos[d] = (s - 1) % 16;
        end
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [27:0] exp_seg,
                             input logic [3:0] exp_dp, input int exp_cnt);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s_seg%0d", tag, d), seg_seen[d], exp_seg[d*7 +: 7]);
      check($sformatf("%s_dp%0d", tag, d), dp_seen[d], exp_dp[d]);
      check($sformatf("%s_cnt%0d", tag, d), low_cnt[d], exp_cnt);
    end
    check($sformatf("%s_tick", tag), tick_pos, 64);
  endtask

  initial begin
    int wait_cnt;
    reset = 1'b1; en = 1'b1; blank_lz = 1'b0; dig_in = 16'h1234;
    dp_in = 4'b0000; bright = 4'd15;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // mid-run reset: digit 1 lit at prescaler 13 before the asynchronous reset
    repeat (30) @(negedge clk);
    check("pre_reset_an", an, 4'b1101);
    #2 reset = 1'b1;
    #1;
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_tick", frame_tick, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    capture_frame(0, 16'h0);
    check_frame("first", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 15);
    capture_frame(0, 16'h0);
    check_frame("f1234", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 15);

    // leading zeros
    dig_in = 16'h0005; blank_lz = 1'b1;
    capture_frame(0, 16'h0);
    check_frame("old1234", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 15);
    capture_frame(0, 16'h0);
    check_frame("lz0005", {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'hF, 15);
    dig_in = 16'h0000;
    capture_frame(0, 16'h0);
    capture_frame(0, 16'h0);
    check_frame("lz0000", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 15);
    blank_lz = 1'b0;
    capture_frame(0, 16'h0);
    check_frame("nolz0000", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 15);

    // snapshot coherence
    dig_in = 16'h0099;
    capture_frame(0, 16'h0);
    capture_frame(32, 16'h0100);
    check_frame("coh0099", {7'h40, 7'h40, 7'h10, 7'h10}, 4'hF, 15);
    blank_lz = 1'b1;
    capture_frame(0, 16'h0);
    check_frame("coh0100", {7'h7F, 7'h79, 7'h40, 7'h40}, 4'hF, 15);

    // hex digits and decimal points
    dig_in = 16'hABCF; dp_in = 4'b0101;
    capture_frame(0, 16'h0);
    capture_frame(0, 16'h0);
    check_frame("hexdp", {7'h08, 7'h03, 7'h46, 7'h0E}, 4'b1010, 15);
    dig_in = 16'h0000; dp_in = 4'b1000;
    capture_frame(0, 16'h0);
    capture_frame(0, 16'h0);
    check_frame("blankdp", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0111, 15);

    // en toggle: freeze in digit 1 at prescaler 5, then resume
    repeat (21) @(negedge clk);
    check("en_pre_an", an, 4'b1101);
    en = 1'b0;
    @(negedge clk);
    check("en_off_an", an, 4'hF);
    repeat (10) @(negedge clk);
    check("en_held_an", an, 4'hF);
    en = 1'b1;
    @(negedge clk);
    check("en_resume_an", an, 4'b1101);
    wait_cnt = 0;
    while (!frame_tick && wait_cnt < 200) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("en_resume_tick_dist", wait_cnt, 42);

    // brightness
    bright = 4'd0;
    capture_frame(0, 16'h0);
    check_frame("bright0", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0111, 1);
    check("bright0_pos", first_pos[0], 1);
    bright = 4'd7;
    capture_frame(0, 16'h0);
    check_frame("bright7", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0111, 7);
    check("bright7_pos", first_pos[2], 1);

    check("multi_anode_low", multi_low, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Time-multiplexed seven-segment display driver that consumes packed 4-bit digit values, such as the BCD digits from the mod-100 counter or a stopwatch. It scans one digit per refresh slot and takes a coherent snapshot of the inputs once per frame, so a digit never tears mid-frame. It adds leading-zero blanking, per-digit decimal points and 16-level PWM brightness. It sits directly between the counter stages and the board's anode/cathode pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_LOG2, 16, log2 of clock cycles per digit slot (>=4)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
en  in  1  scan enable; 0 = display dark, scan frozen
blank_lz  in  1  1 = blank leading zeros
dig_in  in  4*NUM_DIGITS  packed digits; [3:0] = digit 0 (least significant)
dp_in  in  NUM_DIGITS  decimal point request per digit, active-high
bright  in  4  brightness, 0 = dimmest, 15 = full
an  out  NUM_DIGITS  anode enables, active-low
seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal-point cathode, active-low
frame_tick  out  1  one-cycle pulse at each frame start

Behaviour:
- Reset: clk and reset are as decided above (reset asynchronous, active-high). Reset drives an = all 1, seg = 7'h7F, dp = 1, frame_tick = 0, and clears prescaler, digit index and shadow registers.
- Prescaler (REFRESH_LOG2 bits) increments every cycle while en = 1.
  - At all-ones it wraps to 0 and the index advances.
  - Index wraps from NUM_DIGITS-1 to 0.
- Frame start = the cycle where prescaler wraps and index goes from NUM_DIGITS-1 to 0.
  - At frame start, dig_in and dp_in are captured into shadow registers.
  - frame_tick is asserted the following cycle, for 1 cycle.
  - The first snapshot is taken at the first frame start after reset. Until then, shadow = 0.
- Display path uses shadow values only. Input changes mid-frame are invisible until the next frame.
- Decode (value -> seg):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - A=08, b=03, C=46, d=21, E=06, F=0E (hex)
  - blank = 7F
- Leading-zero blanking: digit k is blanked when blank_lz = 1 and shadow digits k..NUM_DIGITS-1 are all 0. Digit 0 is never blanked.
- Decimal point: a blanked digit still shows its decimal point if its dp_in shadow bit is 1.
- Anode on-condition for the current index:
  - en = 1, AND
  - prescaler != 0 (one-cycle dead time per slot, anti-ghosting), AND
  - prescaler[REFRESH_LOG2-1 -: 4] <= bright.
  - bright = 15 means on for the whole slot except the dead cycle.
- Exactly one anode is low, or none. Never two.
- Outputs an, seg and dp are registered: one cycle latency from the prescaler/index state.
- en deassert: next cycle an = all 1. Prescaler and index hold. Resume continues from the held state.
- bright is sampled every cycle; a change takes effect the next cycle.
- Reset mid-frame: outputs go dark immediately (asynchronous). Scanning restarts from index 0 and prescaler 0.

Decomposition:
- Shared package holds:
  - the 16 seven-segment code constants and SEG_BLANK = 7'h7F
  - the width helper localparam for the packed digit bus.
- One combinational sub-module, seg7_decode: 4-bit value + blank -> 7-bit active-low code. It is reusable by other display stages.
- Prescaler, index, snapshot, blanking and PWM stay in seg_scan_driver.

Test Plan (NUM_DIGITS = 4, REFRESH_LOG2 = 4, i.e. 16-cycle slots):
- Reset/first frame: assert reset mid-run, release, hold en = 1, dig_in = 16'h1234, blank_lz = 0, bright = 15.
  - During reset: an = 4'hF, seg = 7F, dp = 1.
  - First frame: all digits show 40 (0) because the shadow is still 0.
  - First frame_tick at cycle 64.
  - Next frame: digit 0 = 19 (4) ... digit 3 = 79 (1), each with 15 anode-low cycles per 16.
- Leading zeros: dig_in = 16'h0005, blank_lz = 1.
  - Digits 3..1 show 7F, digit 0 shows 12.
  - With dig_in = 16'h0000: digit 0 shows 40, others 7F.
  - With blank_lz = 0: all digits shown.
- Snapshot coherence: change dig_in from 16'h0099 to 16'h0100 mid-frame.
  - Current frame still shows 0,0,9,9.
  - Next frame shows 0100, with blanking applied if blank_lz = 1.
- Brightness: bright = 0 -> per slot the anode is low only on the cycle with prescaler = 1, i.e. 1 cycle. bright = 7 -> low for cycles 1..7.
- en toggle: drop en mid-slot -> an = 4'hF the next cycle and the index is frozen. Raise en -> resume at the same digit and prescaler.
- Hex/dp: dig_in = 16'hABCF, dp_in = 4'b0101, blank_lz = 1.
  - Codes: digit 0 = 0E, digit 1 = 46, digit 2 = 03, digit 3 = 08.
  - dp = 0 on digits 0 and 2 only.
- Assert throughout: no cycle with more than one anode low.
